csr_trap_unit: RTL

Machine-mode CSR file and trap sequencer. It consumes the control strobes from the exception decoder (ecall, mret, csrWrite, csrSrc, csrLUCtrl) and performs the matching actions:
- CSR read-modify-write.
- Trap entry on ecall and return on mret.
- Free-running mcycle/minstret counters.
It sits beside the register file in the execute stage, supplies the CSR read value to rd writeback, and supplies the redirect target to next-PC selection.

---
 rtl/csr_trap_unit_pkg.sv | 37 +++
 rtl/csr_trap_unit_if.sv | 30 +++
 rtl/csr_counter64.sv | 34 +++
 rtl/csr_trap_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, read-modify-write opcodes, cause codes and mstatus layout.
package csr_trap_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_W   = 2'b01,
    CSR_S   = 2'b10,
    CSR_C   = 2'b11
  } csr_op_e;

  localparam int MCAUSE_ECALL_M = 11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Decoder-to-CSR-unit bundle: strobes and operands in, read data,
// redirect and illegal flag out.
interface csr_trap_unit_if #(parameter int XLEN = 32);
  logic            i_ecall;
  logic            i_mret;
  logic            i_csrWrite;
  logic            i_csrSrc;
  logic [1:0]      i_csrLUCtrl;
  logic [11:0]     i_csrAddr;
  logic [4:0]      i_rs1Field;
  logic [XLEN-1:0] i_rs1Data;
  logic [XLEN-1:0] i_pc;
  logic            i_retire;
  logic [XLEN-1:0] o_csrRdata;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirectPc;
  logic            o_csrIllegal;

  modport master (
    output i_ecall, i_mret, i_csrWrite, i_csrSrc, i_csrLUCtrl, i_csrAddr,
           i_rs1Field, i_rs1Data, i_pc, i_retire,
    input  o_csrRdata, o_redirect, o_redirectPc, o_csrIllegal
  );

  modport slave (
    input  i_ecall, i_mret, i_csrWrite, i_csrSrc, i_csrLUCtrl, i_csrAddr,
           i_rs1Field, i_rs1Data, i_pc, i_retire,
    output o_csrRdata, o_redirect, o_redirectPc, o_csrIllegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter split into two halves with independent write ports;
// any write in a cycle suppresses the increment of both halves.
module csr_counter64 #(
  parameter int HALF = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_en,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [HALF-1:0] wdata,
  output logic [HALF-1:0] lo,
  output logic [HALF-1:0] hi
);

  logic [2*HALF-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[HALF-1:0]      <= wdata;
      if (wr_hi) count[2*HALF-1:HALF] <= wdata;
    end else if (inc_en) begin
      count <= count + 1'b1;
    end
  end

  assign lo = count[HALF-1:0];
  assign hi = count[2*HALF-1:HALF];

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ecall/mret trap sequencing and mcycle/minstret.
// Trap state (NORMAL/TRAP) is carried entirely by mstatus MIE/MPIE.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int              ECALL_CAUSE = MCAUSE_ECALL_M
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  csr_trap_unit_if.slave bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
  logic [XLEN-1:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

  logic [XLEN-1:0] operand, old_val, new_val, mstatus_val;
  logic            csr_active, implemented, csr_wr_en;
  csr_op_e         lu_op;

  // Ecall and mret outrank a CSR instruction and drop it completely.
  assign csr_active  = bus.i_csrWrite && !bus.i_ecall && !bus.i_mret;
  assign implemented = csr_is_implemented(bus.i_csrAddr);
  assign lu_op       = csr_op_e'(bus.i_csrLUCtrl);
  assign operand     = bus.i_csrSrc ? XLEN'(bus.i_rs1Field) : bus.i_rs1Data;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    mstatus_val                               = '0;
    mstatus_val[MSTATUS_MIE]                  = mie;
    mstatus_val[MSTATUS_MPIE]                 = mpie;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    old_val = '0;
    case (bus.i_csrAddr)
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MTVEC:     old_val = mtvec;
      CSR_MSCRATCH:  old_val = mscratch;
      CSR_MEPC:      old_val = mepc;
      CSR_MCAUSE:    old_val = mcause;
      CSR_MCYCLE:    old_val = mcycle_lo;
      CSR_MCYCLEH:   old_val = mcycle_hi;
      CSR_MINSTRET:  old_val = minstret_lo;
      CSR_MINSTRETH: old_val = minstret_hi;
      default:       old_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (lu_op)
      CSR_W:   new_val = operand;
      CSR_S:   new_val = old_val | operand;
      CSR_C:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end

  // csrrs/csrrc with rs1 = x0 (or zimm = 0) is a pure read.
  assign csr_wr_en = csr_active && implemented && (lu_op != CSR_NOP) &&
                     !((lu_op == CSR_S || lu_op == CSR_C) && bus.i_rs1Field == 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN_MASK;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (bus.i_ecall) begin
      mepc   <= bus.i_pc & ALIGN_MASK;
      mcause <= XLEN'(ECALL_CAUSE);
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (bus.i_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_wr_en) begin
      case (bus.i_csrAddr)
        CSR_MSTATUS: begin
          mie  <= new_val[MSTATUS_MIE];
          mpie <= new_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= new_val & ALIGN_MASK;
        CSR_MSCRATCH: mscratch <= new_val;
        CSR_MEPC:     mepc     <= new_val & ALIGN_MASK;
        CSR_MCAUSE:   mcause   <= new_val;
        default:      ;
      endcase
    end
  end

  csr_counter64 #(.HALF(XLEN)) u_mcycle (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc_en(1'b1),
    .wr_lo (csr_wr_en && bus.i_csrAddr == CSR_MCYCLE),
    .wr_hi (csr_wr_en && bus.i_csrAddr == CSR_MCYCLEH),
    .wdata (new_val),
    .lo    (mcycle_lo),
    .hi    (mcycle_hi)
  );

  csr_counter64 #(.HALF(XLEN)) u_minstret (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc_en(bus.i_retire),
    .wr_lo (csr_wr_en && bus.i_csrAddr == CSR_MINSTRET),
    .wr_hi (csr_wr_en && bus.i_csrAddr == CSR_MINSTRETH),
    .wdata (new_val),
    .lo    (minstret_lo),
    .hi    (minstret_hi)
  );

  assign bus.o_csrRdata   = csr_active ? old_val : '0;
  assign bus.o_csrIllegal = i_rst_n && csr_active && !implemented;
  assign bus.o_redirect   = i_rst_n && (bus.i_ecall || bus.i_mret);
  assign bus.o_redirectPc = bus.i_ecall ? mtvec : (bus.i_mret ? mepc : '0);

endmodule
